// File: rtl/input_conditioner.sv
// input_conditioner: multi-channel button front end.
// Each channel synchronises its raw level, debounces both edges symmetrically,
// emits one-cycle press/release pulses, and can auto-repeat while held.
// Repeat timing is driven by an external tick strobe.
//
// Ports:
//   clk_i            system clock
//   reset_ni         synchronous active-low reset
//   raw_i            asynchronous button levels, active high
//   tick_i           one-cycle timing strobe used by the repeat timers
//   repeat_cancel_i  one-cycle strobe that stops repeating on held channels
//   debounced_o      filtered level per channel
//   pressed_o        one-cycle pulse on a debounced rising edge
//   released_o       one-cycle pulse on a debounced falling edge
//   action_o         pressed OR auto-repeat pulse
module input_conditioner #(
    parameter int unsigned          CHANNELS     = 5,
    parameter int unsigned          SYNC_STAGES  = 2,
    parameter int unsigned          DB_BITS      = 13,
    parameter logic [CHANNELS-1:0]  REPEAT_MASK  = CHANNELS'(5'b00111),
    parameter int unsigned          DELAY_TICKS  = 10,
    parameter int unsigned          PERIOD_TICKS = 3
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic [CHANNELS-1:0] raw_i,
    input  logic                tick_i,
    input  logic                repeat_cancel_i,
    output logic [CHANNELS-1:0] debounced_o,
    output logic [CHANNELS-1:0] pressed_o,
    output logic [CHANNELS-1:0] released_o,
    output logic [CHANNELS-1:0] action_o
);

    localparam int unsigned MaxTicks = (DELAY_TICKS > PERIOD_TICKS) ? DELAY_TICKS : PERIOD_TICKS;
    localparam int unsigned RepBits  = $clog2(MaxTicks + 1);
    // Counter value at which the next tick expires the interval.
    localparam logic [RepBits-1:0] DelayLast  = RepBits'(DELAY_TICKS - 1);
    localparam logic [RepBits-1:0] PeriodLast = RepBits'(PERIOD_TICKS - 1);

    typedef enum logic [1:0] {StIdle, StDelay, StRepeat, StHeld} rep_state_e;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [DB_BITS-1:0]     db_cnt_q, db_cnt_d;
        logic                   level_q, level_d;
        logic                   rise, fall;
        logic                   pressed_q, released_q, action_q;
        logic                   rep_pulse;
        logic                   s;

        assign s = sync_q[SYNC_STAGES-1];

        always_ff @(posedge clk_i) begin
            if (!reset_ni) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i[i]};
            end
        end

        // Count consecutive disagreeing samples; any agreement restarts the count.
        always_comb begin
            db_cnt_d = '0;
            level_d  = level_q;
            rise     = 1'b0;
            fall     = 1'b0;
            if (s != level_q) begin
                if (db_cnt_q == '1) begin
                    level_d = s;
                    rise    = s;
                    fall    = ~s;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (!reset_ni) begin
                db_cnt_q   <= '0;
                level_q    <= 1'b0;
                pressed_q  <= 1'b0;
                released_q <= 1'b0;
                action_q   <= 1'b0;
            end else begin
                db_cnt_q   <= db_cnt_d;
                level_q    <= level_d;
                pressed_q  <= rise;
                released_q <= fall;
                action_q   <= rise | rep_pulse;
            end
        end

        if (REPEAT_MASK[i]) begin : g_rep
            rep_state_e         state_q, state_d;
            logic [RepBits-1:0] cnt_q, cnt_d;

            // Triggered by the registered press/release pulses so a tick in the
            // press cycle is never counted and action cannot fire back to back.
            always_comb begin
                state_d   = state_q;
                cnt_d     = cnt_q;
                rep_pulse = 1'b0;
                unique case (state_q)
                    StIdle: begin
                        if (pressed_q) begin
                            cnt_d   = '0;
                            state_d = StDelay;
                        end
                    end
                    StDelay: begin
                        if (released_q) begin
                            state_d = StIdle;
                        end else if (repeat_cancel_i) begin
                            state_d = StHeld;
                        end else if (tick_i) begin
                            if (cnt_q == DelayLast) begin
                                rep_pulse = 1'b1;
                                cnt_d     = '0;
                                state_d   = StRepeat;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                    end
                    StRepeat: begin
                        if (released_q) begin
                            state_d = StIdle;
                        end else if (repeat_cancel_i) begin
                            state_d = StHeld;
                        end else if (tick_i) begin
                            if (cnt_q == PeriodLast) begin
                                rep_pulse = 1'b1;
                                cnt_d     = '0;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                    end
                    StHeld: begin
                        if (released_q) begin
                            state_d = StIdle;
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end

            always_ff @(posedge clk_i) begin
                if (!reset_ni) begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                end
            end
        end else begin : g_norep
            assign rep_pulse = 1'b0;
        end

        assign debounced_o[i] = level_q;
        assign pressed_o[i]   = pressed_q;
        assign released_o[i]  = released_q;
        assign action_o[i]    = action_q;
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner (DB_BITS=3, SYNC_STAGES=2,
// DELAY_TICKS=3, PERIOD_TICKS=2, CHANNELS=5).
// Stimulus pushes every expected pulse cycle; the monitor pops one entry per
// cycle in which any pulse output is high. Unexpected pulses and leftovers fail.
module tb_input_conditioner;

    localparam int LAT = 10;  // raw change to visible output, in cycles

    typedef struct packed {
        int         cyc;
        logic [4:0] deb;
        logic [4:0] prs;
        logic [4:0] rel;
        logic [4:0] act;
    } ev_t;

    logic       clk;
    logic       reset_n;
    logic [4:0] raw;
    logic       tick;
    logic       repeat_cancel;
    logic [4:0] debounced, pressed, released, action;

    int  cyc = 0;
    int  tests = 0;
    int  fails = 0;
    bit  mon_en = 1'b0;
    ev_t exp_q[$];

    input_conditioner #(
        .CHANNELS     (5),
        .SYNC_STAGES  (2),
        .DB_BITS      (3),
        .REPEAT_MASK  (5'b00111),
        .DELAY_TICKS  (3),
        .PERIOD_TICKS (2)
    ) dut (
        .clk_i           (clk),
        .reset_ni        (reset_n),
        .raw_i           (raw),
        .tick_i          (tick),
        .repeat_cancel_i (repeat_cancel),
        .debounced_o     (debounced),
        .pressed_o       (pressed),
        .released_o      (released),
        .action_o        (action)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every pulse cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (mon_en && ((pressed | released | action) != 5'b0)) begin
            ev_t got;
            got = '{cyc: cyc, deb: debounced, prs: pressed, rel: released, act: action};
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse: got cyc=%0d deb=%b prs=%b rel=%b act=%b, required none",
                         got.cyc, got.deb, got.prs, got.rel, got.act);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (got != e) begin
                    fails++;
                    $display("FAIL event: got cyc=%0d deb=%b prs=%b rel=%b act=%b, required cyc=%0d deb=%b prs=%b rel=%b act=%b",
                             got.cyc, got.deb, got.prs, got.rel, got.act,
                             e.cyc, e.deb, e.prs, e.rel, e.act);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [4:0] d, input logic [4:0] p,
                        input logic [4:0] r, input logic [4:0] a);
        exp_q.push_back('{cyc: c, deb: d, prs: p, rel: r, act: a});
    endtask

    task automatic check_zero(input string name);
        tests++;
        if ({debounced, pressed, released, action} != 20'b0) begin
            fails++;
            $display("FAIL %s: got deb=%b prs=%b rel=%b act=%b, required all zero",
                     name, debounced, pressed, released, action);
        end
    endtask

    // n ticks, one every gap cycles; vec bit j marks a repeat pulse on tick j.
    task automatic do_ticks(input int n, input int gap, input logic [15:0] vec,
                            input int cancel_j, input logic [4:0] deb, input logic [4:0] ch);
        for (int j = 0; j < n; j++) begin
            step(gap - 1);
            tick = 1'b1;
            if (j == cancel_j) repeat_cancel = 1'b1;
            if (vec[j]) push(cyc + 1, deb, 5'b0, 5'b0, ch);
            step(1);
            tick          = 1'b0;
            repeat_cancel = 1'b0;
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        raw           = 5'b0;
        tick          = 1'b0;
        repeat_cancel = 1'b0;
        step(3);
        check_zero("reset_state");

        // 1: press on channel 0 appears LAT cycles after raw rises.
        reset_n = 1'b1;
        mon_en  = 1'b1;
        raw[0]  = 1'b1;
        push(cyc + LAT, 5'b00001, 5'b00001, 5'b0, 5'b00001);
        step(LAT);

        // 3: repeats on ticks 3, 5, 7 while held.
        do_ticks(8, 16, 16'b0000_0000_0101_0100, -1, 5'b00001, 5'b00001);
        raw[0] = 1'b0;
        push(cyc + LAT, 5'b0, 5'b0, 5'b00001, 5'b0);
        step(LAT);
        do_ticks(4, 16, 16'b0, -1, 5'b0, 5'b0);

        // 2: bounce shorter than the debounce window is ignored.
        for (int k = 0; k < 25; k++) begin
            raw[1] = ~raw[1];
            step(4);
        end
        raw[1] = 1'b0;
        step(20);

        // 4: channel 3 has no repeat.
        raw[3] = 1'b1;
        push(cyc + LAT, 5'b01000, 5'b01000, 5'b0, 5'b01000);
        step(LAT);
        do_ticks(10, 16, 16'b0, -1, 5'b01000, 5'b01000);
        raw[3] = 1'b0;
        push(cyc + LAT, 5'b0, 5'b0, 5'b01000, 5'b0);
        step(LAT + 5);

        // 5: cancel on the expiring tick suppresses repeats until re-press.
        repeat_cancel = 1'b1;  // idle cancel, no effect
        step(1);
        repeat_cancel = 1'b0;
        raw[0] = 1'b1;
        push(cyc + LAT, 5'b00001, 5'b00001, 5'b0, 5'b00001);
        step(LAT);
        do_ticks(15, 16, 16'b0000_0000_0000_0100, 4, 5'b00001, 5'b00001);
        raw[0] = 1'b0;
        push(cyc + LAT, 5'b0, 5'b0, 5'b00001, 5'b0);
        step(LAT + 5);
        raw[0] = 1'b1;
        push(cyc + LAT, 5'b00001, 5'b00001, 5'b0, 5'b00001);
        step(LAT);
        do_ticks(7, 16, 16'b0000_0000_0101_0100, -1, 5'b00001, 5'b00001);
        raw[0] = 1'b0;
        push(cyc + LAT, 5'b0, 5'b0, 5'b00001, 5'b0);
        step(LAT + 5);

        // 6: reset during DELAY clears everything; held buttons re-press.
        raw = 5'b00101;
        push(cyc + LAT, 5'b00101, 5'b00101, 5'b0, 5'b00101);
        step(LAT);
        do_ticks(2, 16, 16'b0, -1, 5'b00101, 5'b00101);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        check_zero("mid_reset");
        push(cyc + LAT, 5'b00101, 5'b00101, 5'b0, 5'b00101);
        step(LAT);
        raw = 5'b0;
        push(cyc + LAT, 5'b0, 5'b0, 5'b00101, 5'b0);
        step(LAT + 20);

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL missing_events: got %0d pending, required 0 (next cyc=%0d)",
                     exp_q.size(), exp_q[0].cyc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Multi-channel successor to the single-bit button debouncer.
- Per channel, it provides:
  - synchronisation of the raw input
  - symmetric debounce (both press and release are filtered)
  - one-cycle press and release event pulses
  - optional auto-repeat ("DAS") timed by an external frame tick
- Sits between `ui_in` button pins and the game logic, replacing the per-button debouncer instances and the press-detection stage.

Parameters:
- CHANNELS, 5, number of independent input channels.
- SYNC_STAGES, 2, synchroniser flops per channel (legal range 2 or more).
- DB_BITS, 13, debounce counter width. A level change is accepted after 2^DB_BITS consecutive disagreeing samples.
- REPEAT_MASK, 5'b00111, per-channel auto-repeat enable. Bit i applies to channel i. Default enables repeat on left, right and down only.
- DELAY_TICKS, 10, ticks from press to the first repeat (1 or more).
- PERIOD_TICKS, 3, ticks between subsequent repeats (1 or more).

Ports:
- clk  in  1  system clock (6.25 MHz in the product).
- reset_n  in  1  synchronous, active-low reset.
- raw  in  CHANNELS  asynchronous button levels, active high.
- tick  in  1  one-cycle timing strobe (one per video frame in the product).
- repeat_cancel  in  1  one-cycle strobe that stops repeating on all held channels.
- debounced  out  CHANNELS  filtered level.
- pressed  out  CHANNELS  one-cycle pulse on a debounced rising edge.
- released  out  CHANNELS  one-cycle pulse on a debounced falling edge.
- action  out  CHANNELS  one-cycle pulse equal to pressed OR the repeat pulse.

Behaviour:
- Reset: while reset_n=0 at a clk edge, the following are cleared:
  - every synchroniser flop, debounce counter, repeat counter and FSM (to IDLE)
  - all outputs (to 0)
- Reset mid-operation abandons any count; no pulse is emitted for the abandoned state.
- Reset is evaluated at every clk edge with priority over all other behaviour.
- All outputs are registered.

- Synchroniser: s[i] is raw[i] delayed by SYNC_STAGES clk cycles.

- Debounce, per channel, with state = debounced[i]:
  - If s == state, the counter is set to 0.
  - If s != state and counter < max, the counter increments.
  - If s != state and counter == 2^DB_BITS-1, then at that edge:
    - debounced toggles
    - counter is set to 0
    - pressed (rise) or released (fall) is asserted for exactly that one cycle
  - Latency: raw stable from sample cycle k gives a debounced change visible SYNC_STAGES+2^DB_BITS cycles after k.
  - Any glitch of one cycle or longer in s restarts the count.

- Repeat FSM, per channel, present only when REPEAT_MASK[i]=1:
  - IDLE:
    - When pressed fires, the counter is set to 0 and the FSM goes to DELAY.
    - A tick in the same cycle as pressed is not counted.
  - DELAY:
    - Each tick increments the counter.
    - On the tick that brings the counter to DELAY_TICKS, a repeat pulse is raised on the next edge, the counter is set to 0 and the FSM goes to REPEAT.
  - REPEAT:
    - Each tick increments the counter.
    - On reaching PERIOD_TICKS, a repeat pulse is raised on the next edge and the counter is set to 0.
  - HELD:
    - No counting and no pulses.
  - Transitions with priority over the above:
    - released fires in DELAY, REPEAT or HELD: the FSM goes to IDLE, with no pulse that cycle.
    - repeat_cancel in DELAY or REPEAT: the FSM goes to HELD.
    - repeat_cancel in IDLE: no effect.
    - repeat_cancel coincident with a tick that would expire the count: cancel wins and no pulse is emitted.
  - Counter width is $clog2(max(DELAY_TICKS,PERIOD_TICKS)+1). The counter never wraps.
- Channels with REPEAT_MASK[i]=0 have no FSM logic; their action equals pressed.
- Channels are fully independent; simultaneous events on different channels all pulse in the same cycle.
- action is never asserted for two consecutive cycles on one channel. This holds because DELAY_TICKS and PERIOD_TICKS are both 1 or more and tick is a strobe.

Test Plan:
Bench parameters: DB_BITS=3, SYNC_STAGES=2, DELAY_TICKS=3, PERIOD_TICKS=2, CHANNELS=5.
1. Reset, then raw[0]=1 held from cycle 0 → debounced[0]=1 and pressed[0]=action[0]=1 first visible at cycle 10, for exactly one cycle; other channels stay 0.
2. raw[1] toggling every 4 cycles for 100 cycles → debounced[1], pressed[1] and released[1] all remain 0.
3. raw[0] held, tick every 16 cycles → action[0] pulses at press, after 3 ticks, then every 2 ticks. raw[0]=0 → released[0] pulses 10 cycles after the drop; no further action.
4. raw[3] (mask bit 0) held through 10 ticks → exactly one action[3] pulse.
5. raw[0] held in REPEAT; repeat_cancel asserted on the same cycle as the expiring tick → no pulse, none for 10 more ticks. Release then re-press → normal press and repeat sequence resumes.
6. raw[0]=raw[2]=1 in DELAY; reset_n=0 for one cycle with raw held → all outputs 0 the next cycle; a fresh pressed on both channels 10 cycles after reset deasserts.
